// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results into a 16x32 register file, advances the PC and sequences one outstanding load.
// Non-load results retire in the accepting cycle; loads stall res_ready from the accept until mem_rvalid.
module writeback_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] alu_res,
  input  logic [3:0]  rd,
  input  logic        wr_en,
  input  logic        is_load,
  input  logic        br_taken,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  output logic [31:0] REG_1,
  output logic [31:0] REG_2,
  output logic [31:0] PC,
  output logic [31:0] retired
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] rf_q [16];
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  ld_rd_q, ld_rd_d;
  logic        ld_wen_q, ld_wen_d;

  logic        accept;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign res_ready = (state_q == IDLE) && !rst;
  assign accept    = res_valid && res_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ld_rd_d    = ld_rd_q;
    ld_wen_d   = ld_wen_q;
    rf_we      = 1'b0;
    rf_waddr   = 4'd0;
    rf_wdata   = 32'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            ld_rd_d    = rd;
            ld_wen_d   = wr_en;
            mem_addr_d = alu_res;
            mem_req_d  = 1'b1;
            state_d    = LOAD_WAIT;
          end else begin
            rf_we     = wr_en;
            rf_waddr  = rd;
            rf_wdata  = alu_res;
            pc_d      = br_taken ? {alu_res[31:2], 2'b00} : pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid) begin
          rf_we     = ld_wen_q;
          rf_waddr  = ld_rd_q;
          rf_wdata  = mem_rdata;
          pc_d      = pc_q + 32'd4;
          retired_d = retired_q + 32'd1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset edge must never commit a write, even mid-load.
    if (rst) rf_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      retired_q  <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      ld_rd_q    <= 4'd0;
      ld_wen_q   <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ld_rd_q    <= ld_rd_d;
      ld_wen_q   <= ld_wen_d;
      if (rf_we && (rf_waddr != 4'd0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Same-cycle writes are forwarded so the operand path sees the newest value.
  always_comb begin
    REG_1 = rf_q[rs1];
    REG_2 = rf_q[rs2];
    if (rf_we && (rf_waddr == rs1)) REG_1 = rf_wdata;
    if (rf_we && (rf_waddr == rs2)) REG_2 = rf_wdata;
    if (rs1 == 4'd0) REG_1 = 32'd0;
    if (rs2 == 4'd0) REG_2 = 32'd0;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign PC       = pc_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: hand-computed expectations for retire, branch, load, r0, wrap and reset-abort cases.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] alu_res;
  logic [3:0]  rd;
  logic        wr_en;
  logic        is_load;
  logic        br_taken;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [31:0] REG_1;
  logic [31:0] REG_2;
  logic [31:0] PC;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .alu_res(alu_res), .rd(rd), .wr_en(wr_en), .is_load(is_load), .br_taken(br_taken),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1(rs1), .rs2(rs2), .REG_1(REG_1), .REG_2(REG_2),
    .PC(PC), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one result at the negedge; the accept happens at the following posedge.
  task automatic drive(input logic [31:0] res, input logic [3:0] d, input logic we,
                       input logic ld, input logic br);
    @(negedge clk);
    res_valid = 1'b1;
    alu_res   = res;
    rd        = d;
    wr_en     = we;
    is_load   = ld;
    br_taken  = br;
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0;
    is_load   = 1'b0;
    br_taken  = 1'b0;
    wr_en     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); alu_res = '0; rd = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; rs1 = 4'd5; rs2 = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, res_ready}, 32'd0);
    check("rst_pc", PC, 32'h100);
    check("rst_retired", retired, 32'd0);
    check("rst_reg1_r5", REG_1, 32'd0);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", {31'd0, res_ready}, 32'd1);

    // Plain write with same-cycle bypass
    drive(32'hDEAD_BEEF, 4'd3, 1'b1, 1'b0, 1'b0);
    rs1 = 4'd3;
    #1 check("bypass_r3", REG_1, 32'hDEAD_BEEF);
    @(negedge clk); idle_inputs();
    #1 check("hold_r3", REG_1, 32'hDEAD_BEEF);
    check("pc_plus4", PC, 32'h104);
    check("retired_1", retired, 32'd1);

    // Taken branch, no write
    drive(32'h0000_0207, 4'd4, 1'b0, 1'b0, 1'b1);
    rs2 = 4'd4;
    @(negedge clk); idle_inputs();
    #1 check("br_pc", PC, 32'h204);
    check("br_no_write_r4", REG_2, 32'd0);
    check("retired_2", retired, 32'd2);

    // Load with 3-cycle memory delay; br_taken must be ignored
    drive(32'h40, 4'd7, 1'b1, 1'b1, 1'b1);
    rs1 = 4'd7;
    @(negedge clk); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1 check("ld_memreq", {31'd0, mem_req}, 32'd1);
      check("ld_memaddr", mem_addr, 32'h40);
      check("ld_ready_low", {31'd0, res_ready}, 32'd0);
      check("ld_pc_stall", PC, 32'h204);
      @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #1 check("ld_bypass_r7", REG_1, 32'h1234);
    @(negedge clk); mem_rvalid = 1'b0;
    #1 check("ld_r7", REG_1, 32'h1234);
    check("ld_pc", PC, 32'h208);
    check("ld_retired", retired, 32'd3);
    check("ld_memreq_clr", {31'd0, mem_req}, 32'd0);
    check("ld_ready_back", {31'd0, res_ready}, 32'd1);

    // r0 write discarded
    drive(32'hFFFF, 4'd0, 1'b1, 1'b0, 1'b0);
    rs1 = 4'd0;
    #1 check("r0_no_bypass", REG_1, 32'd0);
    @(negedge clk); idle_inputs();
    #1 check("r0_reads0", REG_1, 32'd0);
    check("r0_pc", PC, 32'h20C);

    // PC wrap through 0, branch target masked
    drive(32'hFFFF_FFFE, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); idle_inputs();
    #1 check("br_mask_pc", PC, 32'hFFFF_FFFC);
    drive(32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); idle_inputs();
    #1 check("pc_wrap", PC, 32'd0);
    check("retired_6", retired, 32'd6);

    // Stray mem_rvalid in IDLE
    rs1 = 4'd7; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA;
    #1 check("idle_rvalid_nobyp", REG_1, 32'h1234);
    @(negedge clk); mem_rvalid = 1'b0;
    #1 check("idle_rvalid_r7", REG_1, 32'h1234);
    check("idle_rvalid_ret", retired, 32'd6);
    check("idle_rvalid_pc", PC, 32'd0);

    // Reset during LOAD_WAIT, then a stray response
    drive(32'h80, 4'd7, 1'b1, 1'b1, 1'b0);
    @(negedge clk); idle_inputs();
    #1 check("ld2_memreq", {31'd0, mem_req}, 32'd1);
    check("ld2_memaddr", mem_addr, 32'h80);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    #1 check("abort_memreq", {31'd0, mem_req}, 32'd0);
    check("abort_memaddr", mem_addr, 32'd0);
    check("abort_ready", {31'd0, res_ready}, 32'd1);
    @(negedge clk); mem_rvalid = 1'b0;
    #1 check("abort_r7", REG_1, 32'd0);
    check("abort_pc", PC, 32'h100);
    check("abort_retired", retired, 32'd0);
    check("abort_memreq2", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
